vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_axis_counter.sv | 45 ++++
 rtl/vga_timing_gen.sv | 120 ++++++++++++
 tb/tb_vga_timing_gen.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and sync-window helper
package vga_pkg;

  localparam int unsigned CNT_W = 12;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Sync is asserted over [active+fp, active+fp+sync-1] of an axis.
  function automatic logic in_sync_window(input logic [CNT_W-1:0] count,
                                          input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync);
    int unsigned c;
    c = 32'(count);
    return (c >= active + fp) && (c < active + fp + sync);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with active and sync decode
module vga_axis_counter import vga_pkg::*; #(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int unsigned      TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign wrap = step && (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (step) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (32'(count_q) < ACTIVE);
  assign sync   = in_sync_window(count_q, ACTIVE, FP, SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing with pixel request and registered video outputs
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned COLOR_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [3*COLOR_W-1:0]   pixel_data,
  input  logic                   pixel_valid,
  output logic                   pixel_req,
  output logic [CNT_W-1:0]       x,
  output logic [CNT_W-1:0]       y,
  output logic                   hsync,
  output logic                   vsync,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   de,
  output logic                   frame_start,
  output logic                   underflow
);

  logic [CNT_W-1:0] h_count, v_count;
  logic             h_wrap, h_active, h_sync;
  logic             v_wrap_unused, v_active, v_sync;
  logic             cnt_clear;

  // Holding enable low parks both counters at the origin so re-enable starts a fresh frame.
  assign cnt_clear = reset || !enable;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clock  (clock),
    .reset  (cnt_clear),
    .step   (1'b1),
    .count  (h_count),
    .wrap   (h_wrap),
    .active (h_active),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clock  (clock),
    .reset  (cnt_clear),
    .step   (h_wrap),
    .count  (v_count),
    .wrap   (v_wrap_unused),
    .active (v_active),
    .sync   (v_sync)
  );

  assign pixel_req = enable && h_active && v_active;
  assign x         = h_count;
  assign y         = v_count;

  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 de_q, de_d;
  logic                 fs_q, fs_d;
  logic                 underflow_q, underflow_d;
  logic [3*COLOR_W-1:0] pix_q, pix_d;

  always_comb begin
    hsync_d     = h_sync ? HSYNC_POL : !HSYNC_POL;
    vsync_d     = v_sync ? VSYNC_POL : !VSYNC_POL;
    de_d        = pixel_req;
    pix_d       = (pixel_req && pixel_valid) ? pixel_data : '0;
    fs_d        = pixel_req && (h_count == '0) && (v_count == '0);
    underflow_d = underflow_q || (pixel_req && !pixel_valid);
    if (!enable) begin
      hsync_d     = !HSYNC_POL;
      vsync_d     = !VSYNC_POL;
      de_d        = 1'b0;
      pix_d       = '0;
      fs_d        = 1'b0;
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hsync_q     <= !HSYNC_POL;
      vsync_q     <= !VSYNC_POL;
      de_q        <= 1'b0;
      pix_q       <= '0;
      fs_q        <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      pix_q       <= pix_d;
      fs_q        <= fs_d;
      underflow_q <= underflow_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign underflow   = underflow_q;
  assign red         = pix_q[3*COLOR_W-1 -: COLOR_W];
  assign green       = pix_q[2*COLOR_W-1 -: COLOR_W];
  assign blue        = pix_q[COLOR_W-1 -: COLOR_W];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (default and small timing)
module tb_vga_timing_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [11:0] pixel_data = 12'h000;

  logic        d_req, d_hs, d_vs, d_de, d_fs, d_uf;
  logic [11:0] d_x, d_y;
  logic [3:0]  d_r, d_g, d_b;
  logic        s_req, s_hs, s_vs, s_de, s_fs, s_uf;
  logic [11:0] s_x, s_y;
  logic [3:0]  s_r, s_g, s_b;

  always #5 clock = ~clock;

  vga_timing_gen dut_d (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_req(d_req), .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
    .red(d_r), .green(d_g), .blue(d_b), .de(d_de), .frame_start(d_fs), .underflow(d_uf)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
  ) dut_s (
    .clock(clock), .reset(reset), .enable(enable),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_req(s_req), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
    .red(s_r), .green(s_g), .blue(s_b), .de(s_de), .frame_start(s_fs), .underflow(s_uf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: position is elapsed enabled cycles t; h = t mod H_TOTAL, v = t div H_TOTAL.
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } tim_t;

  typedef struct {
    int          t;
    bit          live, hs, vs, de, fs, uf;
    logic [11:0] col;
  } mdl_t;

  tim_t td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  tim_t ts = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1};
  mdl_t md = '{default: 0};
  mdl_t ms = '{default: 0};

  task automatic step_model(input tim_t tm, inout mdl_t m);
    int ht, vt, h, v;
    bit req;
    ht  = tm.ha + tm.hf + tm.hs + tm.hb;
    vt  = tm.va + tm.vf + tm.vs + tm.vb;
    h   = m.t % ht;
    v   = m.t / ht;
    req = enable && (h < tm.ha) && (v < tm.va);
    if (reset || !enable) begin
      m.hs  = !tm.hp;
      m.vs  = !tm.vp;
      m.de  = 1'b0;
      m.fs  = 1'b0;
      m.col = 12'h000;
      if (reset) begin
        m.uf   = 1'b0;
        m.live = 1'b1;
      end
      m.t = 0;
    end else begin
      m.hs  = (h >= tm.ha + tm.hf && h < tm.ha + tm.hf + tm.hs) ? tm.hp : !tm.hp;
      m.vs  = (v >= tm.va + tm.vf && v < tm.va + tm.vf + tm.vs) ? tm.vp : !tm.vp;
      m.de  = req;
      m.fs  = req && (m.t == 0);
      m.col = (req && pixel_valid) ? pixel_data : 12'h000;
      if (req && !pixel_valid) m.uf = 1'b1;
      m.t = (m.t + 1) % (ht * vt);
    end
  endtask

  task automatic check_reg(input string tag, input mdl_t m, input logic hs, input logic vs,
                           input logic de, input logic fs, input logic uf, input logic [11:0] col);
    chk({tag, "_hsync"}, hs, m.hs);
    chk({tag, "_vsync"}, vs, m.vs);
    chk({tag, "_de"}, de, m.de);
    chk({tag, "_frame_start"}, fs, m.fs);
    chk({tag, "_underflow"}, uf, m.uf);
    chk({tag, "_colour"}, col, m.col);
  endtask

  task automatic check_comb(input string tag, input tim_t tm, input mdl_t m,
                            input logic req, input logic [11:0] x, input logic [11:0] y);
    int ht, h, v;
    bit er;
    ht = tm.ha + tm.hf + tm.hs + tm.hb;
    h  = m.t % ht;
    v  = m.t / ht;
    er = enable && (h < tm.ha) && (v < tm.va);
    chk({tag, "_pixel_req"}, req, er);
    if (er) begin
      chk({tag, "_x"}, x, h);
      chk({tag, "_y"}, y, v);
    end
  endtask

  always @(posedge clock) begin
    step_model(ts, ms);
    step_model(td, md);
  end

  always begin
    @(negedge clock);
    if (ms.live) check_reg("s", ms, s_hs, s_vs, s_de, s_fs, s_uf, {s_r, s_g, s_b});
    if (md.live) check_reg("d", md, d_hs, d_vs, d_de, d_fs, d_uf, {d_r, d_g, d_b});
    #2;
    if (ms.live) check_comb("s", ts, ms, s_req, s_x, s_y);
    if (md.live) check_comb("d", td, md, d_req, d_x, d_y);
  end

  typedef struct {
    int          en, vld;
    logic [11:0] dat;
    int          req, x, y, de, hs, vs, fs, uf;
    logic [11:0] col;
  } vec_t;

  vec_t tbl[8];
  bit   found;
  bit   prev_dhs, prev_shs, prev_svs;
  int   d_fall1, d_rise1, d_fall2;
  int   s_hr1, s_hr2, s_hf1, s_vr1, s_vf1, s_fs1, s_fs2;

  initial begin
    tbl[0] = '{1, 1, 12'hA5C, 1, 0, 0, 1, 0, 0, 1, 0, 12'hA5C};
    tbl[1] = '{1, 1, 12'h123, 1, 1, 0, 1, 0, 0, 0, 0, 12'h123};
    tbl[2] = '{1, 0, 12'hFFF, 1, 2, 0, 1, 0, 0, 0, 1, 12'h000};
    tbl[3] = '{1, 1, 12'h456, 1, 3, 0, 1, 0, 0, 0, 1, 12'h456};
    tbl[4] = '{1, 1, 12'h789, 1, 4, 0, 1, 0, 0, 0, 1, 12'h789};
    tbl[5] = '{0, 1, 12'hABC, 0, 5, 0, 0, 0, 0, 0, 1, 12'h000};
    tbl[6] = '{1, 1, 12'h321, 1, 0, 0, 1, 0, 0, 1, 1, 12'h321};
    tbl[7] = '{1, 0, 12'h777, 1, 1, 0, 1, 0, 0, 0, 1, 12'h000};

    reset = 1'b1; enable = 1'b0; pixel_valid = 1'b0; pixel_data = 12'h000;
    repeat (2) @(negedge clock);
    chk("rst_d_hsync", d_hs, 1);
    chk("rst_d_vsync", d_vs, 1);
    chk("rst_d_de", d_de, 0);
    chk("rst_d_colour", {d_r, d_g, d_b}, 0);
    chk("rst_d_frame_start", d_fs, 0);
    chk("rst_d_underflow", d_uf, 0);
    chk("rst_s_hsync", s_hs, 0);
    chk("rst_s_vsync", s_vs, 0);

    // Starved run to set underflow, then reset mid-line.
    reset = 1'b0; enable = 1'b1; pixel_valid = 1'b0;
    repeat (40) begin
      @(negedge clock);
      pixel_data = 12'($urandom);
    end
    chk("starved_d_underflow", d_uf, 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_d_hsync", d_hs, 1);
    chk("midrst_d_vsync", d_vs, 1);
    chk("midrst_d_de", d_de, 0);
    chk("midrst_d_colour", {d_r, d_g, d_b}, 0);
    chk("midrst_d_underflow", d_uf, 0);
    chk("midrst_s_underflow", s_uf, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      enable      = (tbl[i].en != 0);
      pixel_valid = (tbl[i].vld != 0);
      pixel_data  = tbl[i].dat;
      #2;
      chk("tbl_req", s_req, tbl[i].req);
      if (tbl[i].req != 0) begin
        chk("tbl_x", s_x, tbl[i].x);
        chk("tbl_y", s_y, tbl[i].y);
      end
      if (i == 0) begin
        chk("release_d_req", d_req, 1);
        chk("release_d_x", d_x, 0);
        chk("release_d_y", d_y, 0);
      end
      @(negedge clock);
      chk("tbl_de", s_de, tbl[i].de);
      chk("tbl_hsync", s_hs, tbl[i].hs);
      chk("tbl_vsync", s_vs, tbl[i].vs);
      chk("tbl_frame_start", s_fs, tbl[i].fs);
      chk("tbl_underflow", s_uf, tbl[i].uf);
      chk("tbl_colour", {s_r, s_g, s_b}, tbl[i].col);
      if (i == 0) begin
        chk("a5c_red", d_r, 4'hA);
        chk("a5c_green", d_g, 4'h5);
        chk("a5c_blue", d_b, 4'hC);
        chk("a5c_de", d_de, 1);
        chk("a5c_frame_start", d_fs, 1);
      end
    end

    // Underflow at (10,3) on the default timing.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; enable = 1'b1; pixel_valid = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge clock);
      if (d_req && d_x == 12'd10 && d_y == 12'd3) begin
        found = 1'b1;
        pixel_valid = 1'b0;
      end
    end
    chk("wait_pixel_10_3", found, 1);
    @(negedge clock);
    pixel_valid = 1'b1;
    chk("uf_colour", {d_r, d_g, d_b}, 0);
    chk("uf_de", d_de, 1);
    chk("uf_flag", d_uf, 1);
    repeat (200) @(negedge clock);
    chk("uf_sticky", d_uf, 1);

    // Free-run period measurements for both timings.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0; enable = 1'b1; pixel_valid = 1'b1;
    prev_dhs = 1'b1; prev_shs = 1'b0; prev_svs = 1'b0;
    d_fall1 = -1; d_rise1 = -1; d_fall2 = -1;
    s_hr1 = -1; s_hr2 = -1; s_hf1 = -1; s_vr1 = -1; s_vf1 = -1; s_fs1 = -1; s_fs2 = -1;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clock);
      if (prev_dhs && !d_hs) begin
        if (d_fall1 < 0) d_fall1 = k;
        else if (d_fall2 < 0) d_fall2 = k;
      end
      if (!prev_dhs && d_hs && d_fall1 >= 0 && d_rise1 < 0) d_rise1 = k;
      if (!prev_shs && s_hs) begin
        if (s_hr1 < 0) s_hr1 = k;
        else if (s_hr2 < 0) s_hr2 = k;
      end
      if (prev_shs && !s_hs && s_hf1 < 0) s_hf1 = k;
      if (!prev_svs && s_vs && s_vr1 < 0) s_vr1 = k;
      if (prev_svs && !s_vs && s_vr1 >= 0 && s_vf1 < 0) s_vf1 = k;
      if (s_fs) begin
        if (s_fs1 < 0) s_fs1 = k;
        else if (s_fs2 < 0) s_fs2 = k;
      end
      prev_dhs = d_hs; prev_shs = s_hs; prev_svs = s_vs;
    end
    chk("d_hsync_first_low", d_fall1, 657);
    chk("d_hsync_low_width", d_rise1 - d_fall1, 96);
    chk("d_hsync_period", d_fall2 - d_fall1, 800);
    chk("s_hsync_first_high", s_hr1, 11);
    chk("s_hsync_high_width", s_hf1 - s_hr1, 2);
    chk("s_line_period", s_hr2 - s_hr1, 14);
    chk("s_vsync_first_high", s_vr1, 5 * 14 + 1);
    chk("s_vsync_high_width", s_vf1 - s_vr1, 14);
    chk("s_frame_start_first", s_fs1, 1);
    chk("s_frame_period", s_fs2 - s_fs1,
        (ts.ha + ts.hf + ts.hs + ts.hb) * (ts.va + ts.vf + ts.vs + ts.vb));

    // Enable dropped at h=300 with underflow already set, then re-enabled.
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clock);
      if (d_req && d_x == 12'd299) begin
        found = 1'b1;
        pixel_valid = 1'b0;
      end
    end
    chk("wait_h_299", found, 1);
    @(negedge clock);
    chk("drop_at_x", d_x, 300);
    pixel_valid = 1'b1;
    enable = 1'b0;
    #2;
    chk("drop_req", d_req, 0);
    @(negedge clock);
    chk("drop_hsync", d_hs, 1);
    chk("drop_vsync", d_vs, 1);
    chk("drop_de", d_de, 0);
    chk("drop_colour", {d_r, d_g, d_b}, 0);
    chk("drop_frame_start", d_fs, 0);
    chk("drop_underflow_held", d_uf, 1);
    enable = 1'b1;
    #2;
    chk("reen_req", d_req, 1);
    chk("reen_x", d_x, 0);
    chk("reen_y", d_y, 0);
    @(negedge clock);
    chk("reen_frame_start", d_fs, 1);
    chk("reen_de", d_de, 1);

    // Randomised traffic, checked each cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 499) == 0);
      if (!enable) enable = ($urandom_range(0, 3) == 0);
      else         enable = ($urandom_range(0, 199) != 0);
      pixel_valid = ($urandom_range(0, 7) != 0);
      pixel_data  = 12'($urandom);
    end
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
